// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : 640x480@60 raster constants and coordinate helpers shared by the
//            timing generator and the renderers.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int COORD_W        = 10;
  localparam int COORD_LIMIT    = 1 << COORD_W;
  localparam int MAX_SYNC_DELAY = 4;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [COORD_W-1:0] coord_t;

  // Half-open window test [start, start+len); done in int so a window that
  // ends exactly at COORD_LIMIT does not overflow the coordinate width.
  function automatic logic in_window(input coord_t pos, input int start, input int len);
    return (int'(pos) >= start) && (int'(pos) < start + len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_delay
// Brief    : Resettable shift register aligning sync signals with a
//            registered colour path. DEPTH of 0 is a straight wire.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_delay #(
  parameter int   WIDTH     = 2,
  parameter int   DEPTH     = 1,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  import vga_timing_pkg::*;

  generate
    if (DEPTH < 0 || DEPTH > MAX_SYNC_DELAY) begin : g_bad_depth
      $error("vga_sync_delay: DEPTH %0d outside 0..%0d", DEPTH, MAX_SYNC_DELAY);
    end

    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] r_stage;

      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          r_stage <= {(DEPTH*WIDTH){RESET_VAL}};
        end else begin
          r_stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign dout = r_stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Raster scan counters, active-display flag, delayed syncs, line
//            and frame strobes and a completed-frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP        = vga_timing_pkg::H_FP,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP        = vga_timing_pkg::V_FP,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP,
  parameter int SYNC_DELAY  = 1,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                                vga_clk,
  input  logic                                reset_n,
  output logic [vga_timing_pkg::COORD_W-1:0]  DrawX,
  output logic [vga_timing_pkg::COORD_W-1:0]  DrawY,
  output logic                                blank,
  output logic                                hs,
  output logic                                vs,
  output logic                                line_start,
  output logic                                frame_start,
  output logic [FRAME_CNT_W-1:0]              frame_count
);

  import vga_timing_pkg::*;

  localparam int     c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t c_h_last   = coord_t'(c_h_total - 1);
  localparam coord_t c_v_last   = coord_t'(c_v_total - 1);
  localparam int     c_hs_start = H_ACTIVE + H_FP;
  localparam int     c_vs_start = V_ACTIVE + V_FP;

  generate
    if (c_h_total > COORD_LIMIT || c_v_total > COORD_LIMIT) begin : g_bad_raster
      $error("vga_timing_gen: raster %0dx%0d exceeds %0d", c_h_total, c_v_total, COORD_LIMIT);
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > MAX_SYNC_DELAY) begin : g_bad_delay
      $error("vga_timing_gen: SYNC_DELAY %0d outside 0..%0d", SYNC_DELAY, MAX_SYNC_DELAY);
    end
    if (FRAME_CNT_W < 1) begin : g_bad_fcnt
      $error("vga_timing_gen: FRAME_CNT_W must be at least 1");
    end
  endgenerate

  logic                   r_running;
  coord_t                 r_h;
  coord_t                 r_v;
  logic [FRAME_CNT_W-1:0] r_frame_count;

  logic       w_h_last;
  logic       w_v_last;
  logic       w_line_start;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic [1:0] w_sync_dly;

  assign w_h_last = (r_h == c_h_last);
  assign w_v_last = (r_v == c_v_last);

  // running holds the counters still on the release edge so (0,0) is the
  // first pixel actually presented.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_running     <= 1'b0;
      r_h           <= '0;
      r_v           <= '0;
      r_frame_count <= '0;
    end else begin
      r_running <= 1'b1;
      if (r_running) begin
        if (w_h_last) begin
          r_h <= '0;
          if (w_v_last) begin
            r_v           <= '0;
            r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
          end else begin
            r_v <= r_v + coord_t'(1);
          end
        end else begin
          r_h <= r_h + coord_t'(1);
        end
      end
    end
  end

  assign w_line_start = r_running & (r_h == '0);
  assign w_hs_raw     = ~(r_running & in_window(r_h, c_hs_start, H_SYNC));
  assign w_vs_raw     = ~(r_running & in_window(r_v, c_vs_start, V_SYNC));

  vga_sync_delay #(
    .WIDTH     (2),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (1'b1)
  ) u_sync_delay (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .din     ({w_hs_raw, w_vs_raw}),
    .dout    (w_sync_dly)
  );

  assign DrawX       = r_h;
  assign DrawY       = r_v;
  assign blank       = r_running & in_window(r_h, 0, H_ACTIVE) & in_window(r_v, 0, V_ACTIVE);
  assign line_start  = w_line_start;
  assign frame_start = w_line_start & (r_v == '0);
  assign hs          = w_sync_dly[1];
  assign vs          = w_sync_dly[0];
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Three raster configurations against a position-arithmetic model,
//            with random run lengths and asynchronous mid-frame resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct packed {
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
    int dly; int fw;
  } cfg_t;

  localparam cfg_t C_DFLT = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 16};
  localparam cfg_t C_TINY = '{8, 2, 3, 2, 4, 1, 2, 1, 0, 2};
  localparam cfg_t C_TALL = '{640, 16, 96, 48, 4, 1, 2, 1, 3, 3};

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  logic [9:0]  dflt_x, dflt_y, tiny_x, tiny_y, tall_x, tall_y;
  logic        dflt_bl, dflt_hs, dflt_vs, dflt_ls, dflt_fs;
  logic        tiny_bl, tiny_hs, tiny_vs, tiny_ls, tiny_fs;
  logic        tall_bl, tall_hs, tall_vs, tall_ls, tall_fs;
  logic [15:0] dflt_fc;
  logic [1:0]  tiny_fc;
  logic [2:0]  tall_fc;

  int     n_checks = 0;
  int     n_pass   = 0;
  longint p        = -1;
  longint last_tiny_fs = -1;
  longint last_tall_fs = -1;

  vga_timing_gen u_dut_dflt (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dflt_x), .DrawY(dflt_y),
    .blank(dflt_bl), .hs(dflt_hs), .vs(dflt_vs), .line_start(dflt_ls),
    .frame_start(dflt_fs), .frame_count(dflt_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(C_TINY.ha), .H_FP(C_TINY.hf), .H_SYNC(C_TINY.hsw), .H_BP(C_TINY.hb),
    .V_ACTIVE(C_TINY.va), .V_FP(C_TINY.vf), .V_SYNC(C_TINY.vsw), .V_BP(C_TINY.vb),
    .SYNC_DELAY(C_TINY.dly), .FRAME_CNT_W(C_TINY.fw)
  ) u_dut_tiny (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(tiny_x), .DrawY(tiny_y),
    .blank(tiny_bl), .hs(tiny_hs), .vs(tiny_vs), .line_start(tiny_ls),
    .frame_start(tiny_fs), .frame_count(tiny_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(C_TALL.ha), .H_FP(C_TALL.hf), .H_SYNC(C_TALL.hsw), .H_BP(C_TALL.hb),
    .V_ACTIVE(C_TALL.va), .V_FP(C_TALL.vf), .V_SYNC(C_TALL.vsw), .V_BP(C_TALL.vb),
    .SYNC_DELAY(C_TALL.dly), .FRAME_CNT_W(C_TALL.fw)
  ) u_dut_tall (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(tall_x), .DrawY(tall_y),
    .blank(tall_bl), .hs(tall_hs), .vs(tall_vs), .line_start(tall_ls),
    .frame_start(tall_fs), .frame_count(tall_fc)
  );

  initial forever #5 vga_clk = ~vga_clk;

  // Index of the pixel being presented; -1 while idle or in reset.
  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) p <= -1;
    else          p <= p + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h (pixel %0d, t=%0t)", tag, obs, exp, p, $time);
  endtask

  function automatic void model(input cfg_t c, input longint q,
                                output logic [31:0] xy, output logic [31:0] flags,
                                output logic [31:0] sync, output logic [31:0] fcnt);
    longint ht, vt, x, y, qd, qx, qy;
    logic   hsr, vsr;
    ht    = c.ha + c.hf + c.hsw + c.hb;
    vt    = c.va + c.vf + c.vsw + c.vb;
    xy    = 0;
    flags = 0;
    fcnt  = 0;
    if (q >= 0) begin
      x     = q % ht;
      y     = (q / ht) % vt;
      xy    = 32'(y * 65536 + x);
      flags = {29'd0, (x < c.ha) && (y < c.va), x == 0, (x == 0) && (y == 0)};
      fcnt  = 32'((q / (ht * vt)) % (longint'(1) << c.fw));
    end
    qd  = q - c.dly;
    hsr = 1'b1;
    vsr = 1'b1;
    if (qd >= 0) begin
      qx  = qd % ht;
      qy  = (qd / ht) % vt;
      hsr = !((qx >= c.ha + c.hf) && (qx < c.ha + c.hf + c.hsw));
      vsr = !((qy >= c.va + c.vf) && (qy < c.va + c.vf + c.vsw));
    end
    sync = {30'd0, hsr, vsr};
  endfunction

  task automatic check_inst(input string name, input cfg_t c,
                            input logic [9:0] x, input logic [9:0] y,
                            input logic bl, input logic ls, input logic fs,
                            input logic hsv, input logic vsv, input logic [31:0] fc);
    logic [31:0] e_xy, e_fl, e_sy, e_fc;
    model(c, p, e_xy, e_fl, e_sy, e_fc);
    chk_eq({name, "_xy"},    {6'd0, y, 6'd0, x},      e_xy);
    chk_eq({name, "_flags"}, {29'd0, bl, ls, fs},     e_fl);
    chk_eq({name, "_sync"},  {30'd0, hsv, vsv},       e_sy);
    chk_eq({name, "_fcnt"},  fc,                      e_fc);
  endtask

  task automatic check_all();
    check_inst("dflt", C_DFLT, dflt_x, dflt_y, dflt_bl, dflt_ls, dflt_fs, dflt_hs, dflt_vs, 32'(dflt_fc));
    check_inst("tiny", C_TINY, tiny_x, tiny_y, tiny_bl, tiny_ls, tiny_fs, tiny_hs, tiny_vs, 32'(tiny_fc));
    check_inst("tall", C_TALL, tall_x, tall_y, tall_bl, tall_ls, tall_fs, tall_hs, tall_vs, 32'(tall_fc));
  endtask

  // Per-cycle comparison plus frame-period measurement between frame_start pulses.
  initial forever begin
    @(negedge vga_clk);
    check_all();
    if (p < 0) begin
      last_tiny_fs = -1;
      last_tall_fs = -1;
    end else begin
      if (tiny_fs) begin
        if (last_tiny_fs >= 0) chk_eq("tiny_period", 32'(p - last_tiny_fs), 32'd120);
        last_tiny_fs = p;
      end
      if (tall_fs) begin
        if (last_tall_fs >= 0) chk_eq("tall_period", 32'(p - last_tall_fs), 32'd6400);
        last_tall_fs = p;
      end
    end
  end

  initial begin
    int run_len;
    int hold;
    repeat (5) @(posedge vga_clk);
    @(negedge vga_clk);
    #2 reset_n = 1'b1;

    for (int seg = 0; seg < 6; seg++) begin
      run_len = int'($urandom_range(300, 5000));
      repeat (run_len) @(posedge vga_clk);
      #3 reset_n = 1'b0;
      #1 check_all();
      hold = int'($urandom_range(1, 4));
      repeat (hold) @(negedge vga_clk);
      #2 reset_n = 1'b1;
    end

    repeat (14000) @(posedge vga_clk);
    @(negedge vga_clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
